axi4_lite_reg_slave: RTL and testbench
======================================

Name: axi4_lite_reg_slave

Overview:
AXI4-Lite responder (subordinate) holding a small register file: three read/write 32-bit registers plus one read-only computed register. It is the register target driven by the AXI VIP master agent in the block-design benches. Write and read channels operate independently, with one outstanding transaction per direction.

Parameters:
ADDR_W, 32, AXI address width; decode uses addr[3:2]; addr[ADDR_W-1:4] must be zero.
DATA_W, 32, AXI data width; only 32 supported.

Ports:
aclk  in  1  system clock, all logic on rising edge
aresetn  in  1  reset, asynchronous assert, active-low
s_axi_awaddr  in  ADDR_W  write address
s_axi_awprot  in  3  ignored
s_axi_awvalid  in  1  write address valid
s_axi_awready  out  1  write address ready
s_axi_wdata  in  32  write data
s_axi_wstrb  in  4  byte strobes
s_axi_wvalid  in  1  write data valid
s_axi_wready  out  1  write data ready
s_axi_bresp  out  2  write response
s_axi_bvalid  out  1  write response valid
s_axi_bready  in  1  write response ready
s_axi_araddr  in  ADDR_W  read address
s_axi_arprot  in  3  ignored
s_axi_arvalid  in  1  read address valid
s_axi_arready  out  1  read address ready
s_axi_rdata  out  32  read data
s_axi_rresp  out  2  read response
s_axi_rvalid  out  1  read data valid
s_axi_rready  in  1  read data ready

Behaviour:
- Register map: 0x0 REG0 RW, 0x4 REG1 RW, 0x8 REG2 RW, 0xC SUM RO = (REG0+REG1+REG2) mod 2^32, combinational from the current registers.
- Reset (aresetn=0, async): REG0-2=0; all ready/valid outputs 0; bresp, rresp and rdata = 0. All readies go to 1 on the first aclk edge after release.
- Write FSM states: W_IDLE, W_WAIT_DATA (AW captured), W_WAIT_ADDR (W captured), W_COMMIT, W_RESP.
  - AW and W may arrive in either order or in the same cycle. awready drops once AW is captured; wready drops once W is captured.
  - Both captured at edge N -> W_COMMIT; the register update and bvalid=1 take effect at edge N+1.
  - bvalid and bresp hold until bready; the handshake edge returns the FSM to W_IDLE with awready=wready=1.
  - Byte lane i is written only when wstrb[i]=1. wstrb=0 -> no change, OKAY.
  - Write to 0xC -> SLVERR (2'b10), no state change.
  - Nonzero addr[ADDR_W-1:4] -> DECERR (2'b11), no state change.
  - addr[1:0] ignored.
- Read FSM states: R_IDLE, R_RESP.
  - arready=1 in R_IDLE. On the AR handshake at edge N, rdata and rresp are registered and rvalid=1 from edge N.
  - rdata and rresp are stable while rvalid=1 and rready=0. The rready handshake returns to R_IDLE.
  - Read latency is 1 cycle when rready is held high.
  - Decode error -> rdata=0, rresp=DECERR.
- Simultaneous read and write commit on the same edge to the same register: the read returns the pre-write value.
- Reset asserted mid-transaction: pending transactions are discarded and no response is issued.
- awprot and arprot are unused.

Decomposition:
- Package axi4_lite_pkg:
  - resp constants RESP_OKAY, RESP_EXOKAY, RESP_SLVERR, RESP_DECERR
  - register index enum (REG0, REG1, REG2, SUM)
  - write_state_t and read_state_t enums
  - helper function for byte-strobe merge
- One sub-module, axi4_lite_reg_bank: holds REG0-2 and the SUM adder. It takes a write port (index, data, strobe, enable) and exposes a read port.
- The top level contains only the two channel FSMs.

Test Plan:
- After reset, write 0xDEADBEEF@0x0, 0x0000BEEF@0x4, 0xDEAD0000@0x8 -> each BRESP=OKAY. Then read 0xC -> 0xBD5B7DDE OKAY; reads of 0x0/0x4/0x8 return the written values.
- W presented 3 cycles before AW, then AW 3 cycles before W, each with bready held low 5 cycles -> bvalid stays high and stable, exactly one write per transaction, data correct.
- REG1=0xFFFFFFFF, then write 0x12345678 with wstrb=4'b0101 to 0x4 -> read 0x4 returns 0xFF34FF78.
- Write to 0xC -> SLVERR, SUM unchanged. Write and read at 0x10 -> DECERR, rdata=0, REG0-2 unchanged.
- rready held low 4 cycles after an AR to 0x0 -> rvalid and rdata stable; arready=0 until the handshake.
- Assert aresetn mid-write (after AW, before W) -> all valids drop immediately and REG0-2 read back 0 after release.

Source files
------------

// File: rtl/axi4_lite_reg_slave_pkg.sv
// Shared types for the AXI4-Lite register slave: response codes, register
// indices, channel FSM states and the byte-strobe merge helper.
package axi4_lite_pkg;

    typedef logic [1:0] resp_t;

    localparam resp_t RESP_OKAY   = 2'b00;
    localparam resp_t RESP_EXOKAY = 2'b01;
    localparam resp_t RESP_SLVERR = 2'b10;
    localparam resp_t RESP_DECERR = 2'b11;

    typedef enum logic [1:0] {
        REG0 = 2'd0,
        REG1 = 2'd1,
        REG2 = 2'd2,
        SUM  = 2'd3
    } reg_idx_t;

    typedef enum logic [2:0] {
        W_IDLE,
        W_WAIT_DATA,
        W_WAIT_ADDR,
        W_COMMIT,
        W_RESP
    } write_state_t;

    typedef enum logic {
        R_IDLE,
        R_RESP
    } read_state_t;

    function automatic logic [31:0] strb_merge(input logic [31:0] old_v,
                                               input logic [31:0] new_v,
                                               input logic [3:0]  strb);
        logic [31:0] merged;
        merged = old_v;
        for (int i = 0; i < 4; i++) begin
            if (strb[i]) merged[8*i +: 8] = new_v[8*i +: 8];
        end
        return merged;
    endfunction

endpackage

// File: rtl/axi4_lite_reg_slave_if.sv
// AXI4-Lite bus bundle between the register slave and its master.
interface axi4_lite_reg_slave_if #(parameter int ADDR_W = 32);

    logic [ADDR_W-1:0] s_axi_awaddr;
    logic [2:0]        s_axi_awprot;
    logic              s_axi_awvalid;
    logic              s_axi_awready;
    logic [31:0]       s_axi_wdata;
    logic [3:0]        s_axi_wstrb;
    logic              s_axi_wvalid;
    logic              s_axi_wready;
    logic [1:0]        s_axi_bresp;
    logic              s_axi_bvalid;
    logic              s_axi_bready;
    logic [ADDR_W-1:0] s_axi_araddr;
    logic [2:0]        s_axi_arprot;
    logic              s_axi_arvalid;
    logic              s_axi_arready;
    logic [31:0]       s_axi_rdata;
    logic [1:0]        s_axi_rresp;
    logic              s_axi_rvalid;
    logic              s_axi_rready;

    modport slave (
        input  s_axi_awaddr, s_axi_awprot, s_axi_awvalid,
        input  s_axi_wdata, s_axi_wstrb, s_axi_wvalid,
        input  s_axi_bready,
        input  s_axi_araddr, s_axi_arprot, s_axi_arvalid,
        input  s_axi_rready,
        output s_axi_awready, s_axi_wready,
        output s_axi_bresp, s_axi_bvalid,
        output s_axi_arready,
        output s_axi_rdata, s_axi_rresp, s_axi_rvalid
    );

    modport master (
        output s_axi_awaddr, s_axi_awprot, s_axi_awvalid,
        output s_axi_wdata, s_axi_wstrb, s_axi_wvalid,
        output s_axi_bready,
        output s_axi_araddr, s_axi_arprot, s_axi_arvalid,
        output s_axi_rready,
        input  s_axi_awready, s_axi_wready,
        input  s_axi_bresp, s_axi_bvalid,
        input  s_axi_arready,
        input  s_axi_rdata, s_axi_rresp, s_axi_rvalid
    );

endinterface

// File: rtl/axi4_lite_reg_slave_reg_bank.sv
// Three RW registers with byte-strobed write port and a combinational read
// port; index SUM reads the 32-bit wrapping sum of the three registers.
module axi4_lite_reg_bank
    import axi4_lite_pkg::*;
(
    input  logic        aclk,
    input  logic        aresetn,
    input  logic        wr_en_i,
    input  reg_idx_t    wr_idx_i,
    input  logic [31:0] wr_data_i,
    input  logic [3:0]  wr_strb_i,
    input  reg_idx_t    rd_idx_i,
    output logic [31:0] rd_data_o
);

    logic [31:0] regs_q [3];
    logic [31:0] sum;

    // NOTE: the register file is small enough to reset every entry; a larger
    // RAM-backed bank would be left unreset and initialised by software.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            for (int i = 0; i < 3; i++) regs_q[i] <= '0;
        end else begin
            for (int i = 0; i < 3; i++) begin
                // NOTE: non-blocking so a same-edge read of this register
                // still sees the pre-write value.
                if (wr_en_i && wr_idx_i == reg_idx_t'(2'(i)))
                    regs_q[i] <= strb_merge(regs_q[i], wr_data_i, wr_strb_i);
            end
        end
    end

    assign sum = regs_q[0] + regs_q[1] + regs_q[2];

    always_comb begin
        // NOTE: default first so no path through the case leaves a latch.
        rd_data_o = '0;
        case (rd_idx_i)
            REG0: rd_data_o = regs_q[0];
            REG1: rd_data_o = regs_q[1];
            REG2: rd_data_o = regs_q[2];
            SUM:  rd_data_o = sum;
            default: rd_data_o = '0;
        endcase
    end

endmodule

// File: rtl/axi4_lite_reg_slave.sv
// AXI4-Lite register slave: independent write and read channel FSMs in front
// of the register bank, one outstanding transaction per direction.
module axi4_lite_reg_slave
    import axi4_lite_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                 aclk,
    input  logic                 aresetn,
    axi4_lite_reg_slave_if.slave s_axi
);

    write_state_t      w_state_q;
    logic              awready_q, wready_q, bvalid_q;
    resp_t             bresp_q;
    reg_idx_t          aw_idx_q;
    logic              aw_decerr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [3:0]        wstrb_q;

    read_state_t r_state_q;
    logic        arready_q, rvalid_q;
    resp_t       rresp_q;
    logic [31:0] rdata_q;

    logic        aw_hs, w_hs, ar_hs, ar_decerr, bank_wr_en;
    resp_t       wr_resp;
    reg_idx_t    rd_idx;
    logic [31:0] bank_rd_data;
    logic        unused_ok;

    assign aw_hs     = s_axi.s_axi_awvalid && awready_q;
    assign w_hs      = s_axi.s_axi_wvalid && wready_q;
    assign ar_hs     = s_axi.s_axi_arvalid && arready_q;
    assign rd_idx    = reg_idx_t'(s_axi.s_axi_araddr[3:2]);
    assign ar_decerr = |s_axi.s_axi_araddr[ADDR_W-1:4];

    assign wr_resp    = aw_decerr_q ? RESP_DECERR : (aw_idx_q == SUM) ? RESP_SLVERR : RESP_OKAY;
    assign bank_wr_en = (w_state_q == W_COMMIT) && (wr_resp == RESP_OKAY);

    axi4_lite_reg_bank u_bank (
        .aclk      (aclk),
        .aresetn   (aresetn),
        .wr_en_i   (bank_wr_en),
        .wr_idx_i  (aw_idx_q),
        .wr_data_i (wdata_q),
        .wr_strb_i (wstrb_q),
        .rd_idx_i  (rd_idx),
        .rd_data_o (bank_rd_data)
    );

    // Readies come up on the first edge after reset via the W_IDLE default.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            w_state_q   <= W_IDLE;
            awready_q   <= 1'b0;
            wready_q    <= 1'b0;
            bvalid_q    <= 1'b0;
            bresp_q     <= RESP_OKAY;
            aw_idx_q    <= REG0;
            aw_decerr_q <= 1'b0;
            wdata_q     <= '0;
            wstrb_q     <= '0;
        end else begin
            if (aw_hs) begin
                aw_idx_q    <= reg_idx_t'(s_axi.s_axi_awaddr[3:2]);
                aw_decerr_q <= |s_axi.s_axi_awaddr[ADDR_W-1:4];
            end
            if (w_hs) begin
                wdata_q <= s_axi.s_axi_wdata;
                wstrb_q <= s_axi.s_axi_wstrb;
            end
            case (w_state_q)
                W_IDLE: begin
                    awready_q <= 1'b1;
                    wready_q  <= 1'b1;
                    if (aw_hs && w_hs) begin
                        awready_q <= 1'b0;
                        wready_q  <= 1'b0;
                        w_state_q <= W_COMMIT;
                    end else if (aw_hs) begin
                        awready_q <= 1'b0;
                        w_state_q <= W_WAIT_DATA;
                    end else if (w_hs) begin
                        wready_q  <= 1'b0;
                        w_state_q <= W_WAIT_ADDR;
                    end
                end
                W_WAIT_DATA: if (w_hs) begin
                    wready_q  <= 1'b0;
                    w_state_q <= W_COMMIT;
                end
                W_WAIT_ADDR: if (aw_hs) begin
                    awready_q <= 1'b0;
                    w_state_q <= W_COMMIT;
                end
                W_COMMIT: begin
                    bvalid_q  <= 1'b1;
                    bresp_q   <= wr_resp;
                    w_state_q <= W_RESP;
                end
                W_RESP: if (s_axi.s_axi_bready) begin
                    bvalid_q  <= 1'b0;
                    awready_q <= 1'b1;
                    wready_q  <= 1'b1;
                    w_state_q <= W_IDLE;
                end
                default: w_state_q <= W_IDLE;
            endcase
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_state_q <= R_IDLE;
            arready_q <= 1'b0;
            rvalid_q  <= 1'b0;
            rresp_q   <= RESP_OKAY;
            rdata_q   <= '0;
        end else begin
            case (r_state_q)
                R_IDLE: begin
                    arready_q <= 1'b1;
                    if (ar_hs) begin
                        arready_q <= 1'b0;
                        rvalid_q  <= 1'b1;
                        rdata_q   <= ar_decerr ? 32'h0 : bank_rd_data;
                        rresp_q   <= ar_decerr ? RESP_DECERR : RESP_OKAY;
                        r_state_q <= R_RESP;
                    end
                end
                R_RESP: if (s_axi.s_axi_rready) begin
                    rvalid_q  <= 1'b0;
                    arready_q <= 1'b1;
                    r_state_q <= R_IDLE;
                end
                default: r_state_q <= R_IDLE;
            endcase
        end
    end

    assign s_axi.s_axi_awready = awready_q;
    assign s_axi.s_axi_wready  = wready_q;
    assign s_axi.s_axi_bvalid  = bvalid_q;
    assign s_axi.s_axi_bresp   = bresp_q;
    assign s_axi.s_axi_arready = arready_q;
    assign s_axi.s_axi_rvalid  = rvalid_q;
    assign s_axi.s_axi_rresp   = rresp_q;
    assign s_axi.s_axi_rdata   = rdata_q;

    // Protection bits and the byte offset within a word carry no meaning here.
    assign unused_ok = ^{s_axi.s_axi_awprot, s_axi.s_axi_arprot,
                         s_axi.s_axi_awaddr[1:0], s_axi.s_axi_araddr[1:0]};

endmodule

// File: tb/tb_axi4_lite_reg_slave.sv
// Self-checking bench: directed vector table, hand-written corner sequences
// and randomized traffic compared against a behavioural register-map model.
module tb_axi4_lite_reg_slave;
    import axi4_lite_pkg::*;

    logic aclk = 1'b0;
    logic aresetn = 1'b0;
    always #5 aclk = ~aclk;

    axi4_lite_reg_slave_if #(.ADDR_W(32)) bus ();

    axi4_lite_reg_slave #(.ADDR_W(32), .DATA_W(32)) dut (
        .aclk    (aclk),
        .aresetn (aresetn),
        .s_axi   (bus)
    );

    typedef struct {
        logic        is_write;
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  strb;
        logic [31:0] exp_data;
        logic [1:0]  exp_resp;
    } vec_t;

    int vectors = 0;
    int miscompares = 0;
    logic [31:0] m_regs [3];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic timeout(input string name);
        vectors++;
        miscompares++;
        $display("FAIL %s: handshake timeout", name);
    endtask

    // Reference model: register map arithmetic written straight from the map.
    function automatic logic [1:0] model_write(input logic [31:0] a, input logic [31:0] d,
                                               input logic [3:0] s);
        if (a >= 32'h10) return 2'b11;
        if (a[3:2] == 2'd3) return 2'b10;
        for (int b = 0; b < 4; b++)
            if (s[b]) m_regs[a[3:2]][8*b +: 8] = d[8*b +: 8];
        return 2'b00;
    endfunction

    function automatic logic [31:0] model_read(input logic [31:0] a);
        if (a >= 32'h10) return 32'h0;
        if (a[3:2] == 2'd3) return m_regs[0] + m_regs[1] + m_regs[2];
        return m_regs[a[3:2]];
    endfunction

    function automatic logic [1:0] model_rresp(input logic [31:0] a);
        return (a >= 32'h10) ? 2'b11 : 2'b00;
    endfunction

    task automatic axi_write(input logic [31:0] addr, input logic [31:0] data,
                             input logic [3:0] strb, output logic [1:0] resp);
        logic aw_now, w_now, b_now, done;
        done = 1'b0;
        resp = 2'bxx;
        @(posedge aclk); #1;
        bus.s_axi_awaddr = addr; bus.s_axi_awvalid = 1'b1;
        bus.s_axi_wdata = data; bus.s_axi_wstrb = strb; bus.s_axi_wvalid = 1'b1;
        bus.s_axi_bready = 1'b1;
        for (int c = 0; c < 50 && !done; c++) begin
            @(negedge aclk);
            aw_now = bus.s_axi_awvalid && bus.s_axi_awready;
            w_now  = bus.s_axi_wvalid && bus.s_axi_wready;
            b_now  = bus.s_axi_bvalid && bus.s_axi_bready;
            if (b_now) resp = bus.s_axi_bresp;
            @(posedge aclk); #1;
            if (aw_now) bus.s_axi_awvalid = 1'b0;
            if (w_now) bus.s_axi_wvalid = 1'b0;
            if (b_now) begin
                done = 1'b1;
                bus.s_axi_bready = 1'b0;
            end
        end
        if (!done) begin
            timeout("axi_write");
            bus.s_axi_awvalid = 1'b0; bus.s_axi_wvalid = 1'b0; bus.s_axi_bready = 1'b0;
        end
    endtask

    task automatic axi_read(input logic [31:0] addr, output logic [31:0] data,
                            output logic [1:0] resp);
        logic ar_now, r_now, done;
        done = 1'b0;
        data = 'x;
        resp = 2'bxx;
        @(posedge aclk); #1;
        bus.s_axi_araddr = addr; bus.s_axi_arvalid = 1'b1; bus.s_axi_rready = 1'b1;
        for (int c = 0; c < 50 && !done; c++) begin
            @(negedge aclk);
            ar_now = bus.s_axi_arvalid && bus.s_axi_arready;
            r_now  = bus.s_axi_rvalid && bus.s_axi_rready;
            if (r_now) begin
                data = bus.s_axi_rdata;
                resp = bus.s_axi_rresp;
            end
            @(posedge aclk); #1;
            if (ar_now) bus.s_axi_arvalid = 1'b0;
            if (r_now) begin
                done = 1'b1;
                bus.s_axi_rready = 1'b0;
            end
        end
        if (!done) begin
            timeout("axi_read");
            bus.s_axi_arvalid = 1'b0; bus.s_axi_rready = 1'b0;
        end
    endtask

    // One write with W and AW separated by three cycles and bready held low.
    task automatic seq_split(input logic w_first, input logic [31:0] addr, input logic [31:0] data);
        logic [1:0] exp_resp;
        int n;
        @(posedge aclk); #1;
        bus.s_axi_awaddr = addr; bus.s_axi_wdata = data; bus.s_axi_wstrb = 4'hF;
        bus.s_axi_bready = 1'b0;
        if (w_first) bus.s_axi_wvalid = 1'b1; else bus.s_axi_awvalid = 1'b1;
        @(posedge aclk); #1;
        bus.s_axi_wvalid = 1'b0; bus.s_axi_awvalid = 1'b0;
        repeat (2) @(posedge aclk);
        @(negedge aclk);
        check("split_first_ready_low", w_first ? bus.s_axi_wready : bus.s_axi_awready, 0);
        check("split_other_ready_high", w_first ? bus.s_axi_awready : bus.s_axi_wready, 1);
        check("split_no_early_bvalid", bus.s_axi_bvalid, 0);
        @(posedge aclk); #1;
        if (w_first) bus.s_axi_awvalid = 1'b1; else bus.s_axi_wvalid = 1'b1;
        @(posedge aclk); #1;
        bus.s_axi_wvalid = 1'b0; bus.s_axi_awvalid = 1'b0;
        n = 0;
        while (!bus.s_axi_bvalid && n < 10) begin
            @(posedge aclk); #1;
            n++;
        end
        if (!bus.s_axi_bvalid) timeout("split_bvalid");
        exp_resp = model_write(addr, data, 4'hF);
        for (int i = 0; i < 5; i++) begin
            @(negedge aclk);
            check("split_bvalid_held", bus.s_axi_bvalid, 1);
            check("split_bresp_held", bus.s_axi_bresp, exp_resp);
            check("split_readies_low", {bus.s_axi_awready, bus.s_axi_wready}, 0);
        end
        @(posedge aclk); #1;
        bus.s_axi_bready = 1'b1;
        @(posedge aclk); #1;
        bus.s_axi_bready = 1'b0;
        @(negedge aclk);
        check("split_bvalid_cleared", bus.s_axi_bvalid, 0);
        check("split_readies_back", {bus.s_axi_awready, bus.s_axi_wready}, 2'b11);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vec_t        vecs [$];
        logic [31:0] rd, old_v, new_v, a, d;
        logic [1:0]  rs;
        logic [3:0]  s;

        bus.s_axi_awaddr = '0; bus.s_axi_awprot = '0; bus.s_axi_awvalid = 1'b0;
        bus.s_axi_wdata = '0;  bus.s_axi_wstrb = '0;  bus.s_axi_wvalid = 1'b0;
        bus.s_axi_bready = 1'b0;
        bus.s_axi_araddr = '0; bus.s_axi_arprot = '0; bus.s_axi_arvalid = 1'b0;
        bus.s_axi_rready = 1'b0;
        for (int i = 0; i < 3; i++) m_regs[i] = '0;

        repeat (3) @(posedge aclk);
        #2;
        check("reset_outputs",
              {bus.s_axi_awready, bus.s_axi_wready, bus.s_axi_arready,
               bus.s_axi_bvalid, bus.s_axi_rvalid, bus.s_axi_bresp, bus.s_axi_rresp}, 0);
        check("reset_rdata", bus.s_axi_rdata, 0);
        aresetn = 1'b1;
        #1;
        check("readies_low_before_edge",
              {bus.s_axi_awready, bus.s_axi_wready, bus.s_axi_arready}, 0);
        @(posedge aclk); #1;
        check("readies_high_after_edge",
              {bus.s_axi_awready, bus.s_axi_wready, bus.s_axi_arready}, 3'b111);

        // is_write, addr, data, strb, exp_data, exp_resp
        vecs.push_back('{1'b1, 32'h0,  32'hDEADBEEF, 4'hF, 32'h0,        2'b00});
        vecs.push_back('{1'b1, 32'h4,  32'h0000BEEF, 4'hF, 32'h0,        2'b00});
        vecs.push_back('{1'b1, 32'h8,  32'hDEAD0000, 4'hF, 32'h0,        2'b00});
        vecs.push_back('{1'b0, 32'hC,  32'h0,        4'h0, 32'hBD5B7DDE, 2'b00});
        vecs.push_back('{1'b0, 32'h0,  32'h0,        4'h0, 32'hDEADBEEF, 2'b00});
        vecs.push_back('{1'b0, 32'h4,  32'h0,        4'h0, 32'h0000BEEF, 2'b00});
        vecs.push_back('{1'b0, 32'h8,  32'h0,        4'h0, 32'hDEAD0000, 2'b00});
        vecs.push_back('{1'b1, 32'h4,  32'hFFFFFFFF, 4'hF, 32'h0,        2'b00});
        vecs.push_back('{1'b1, 32'h4,  32'h12345678, 4'h5, 32'h0,        2'b00});
        vecs.push_back('{1'b0, 32'h4,  32'h0,        4'h0, 32'hFF34FF78, 2'b00});
        vecs.push_back('{1'b1, 32'h4,  32'hAAAAAAAA, 4'h0, 32'h0,        2'b00});
        vecs.push_back('{1'b0, 32'h4,  32'h0,        4'h0, 32'hFF34FF78, 2'b00});
        vecs.push_back('{1'b1, 32'hC,  32'h11111111, 4'hF, 32'h0,        2'b10});
        vecs.push_back('{1'b0, 32'hC,  32'h0,        4'h0, 32'hBC8FBE67, 2'b00});
        vecs.push_back('{1'b1, 32'h10, 32'h55555555, 4'hF, 32'h0,        2'b11});
        vecs.push_back('{1'b0, 32'h10, 32'h0,        4'h0, 32'h0,        2'b11});
        vecs.push_back('{1'b0, 32'h0,  32'h0,        4'h0, 32'hDEADBEEF, 2'b00});
        vecs.push_back('{1'b0, 32'h8,  32'h0,        4'h0, 32'hDEAD0000, 2'b00});
        vecs.push_back('{1'b1, 32'h0B, 32'h01020304, 4'hF, 32'h0,        2'b00});
        vecs.push_back('{1'b0, 32'h9,  32'h0,        4'h0, 32'h01020304, 2'b00});

        foreach (vecs[i]) begin
            if (vecs[i].is_write) begin
                axi_write(vecs[i].addr, vecs[i].data, vecs[i].strb, rs);
                check($sformatf("vec%0d_bresp", i), rs, vecs[i].exp_resp);
                void'(model_write(vecs[i].addr, vecs[i].data, vecs[i].strb));
            end else begin
                axi_read(vecs[i].addr, rd, rs);
                check($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_data);
                check($sformatf("vec%0d_rresp", i), rs, vecs[i].exp_resp);
            end
        end

        seq_split(1'b1, 32'h0, 32'hCAFEF00D);
        axi_read(32'h0, rd, rs);
        check("split_w_first_data", rd, model_read(32'h0));
        seq_split(1'b0, 32'h4, 32'h600DD00D);
        axi_read(32'h4, rd, rs);
        check("split_aw_first_data", rd, model_read(32'h4));

        // Read stalled by rready low for four cycles.
        @(posedge aclk); #1;
        bus.s_axi_araddr = 32'h0; bus.s_axi_arvalid = 1'b1; bus.s_axi_rready = 1'b0;
        @(posedge aclk); #1;
        bus.s_axi_arvalid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge aclk);
            check("stall_rvalid", bus.s_axi_rvalid, 1);
            check("stall_rdata", bus.s_axi_rdata, model_read(32'h0));
            check("stall_arready", bus.s_axi_arready, 0);
        end
        @(posedge aclk); #1;
        bus.s_axi_rready = 1'b1;
        @(posedge aclk); #1;
        bus.s_axi_rready = 1'b0;
        @(negedge aclk);
        check("stall_released", {bus.s_axi_rvalid, bus.s_axi_arready}, 2'b01);

        // Read handshake on the same edge as a write commit to the same register.
        old_v = model_read(32'h8);
        new_v = $urandom;
        @(posedge aclk); #1;
        bus.s_axi_awaddr = 32'h8; bus.s_axi_wdata = new_v; bus.s_axi_wstrb = 4'hF;
        bus.s_axi_awvalid = 1'b1; bus.s_axi_wvalid = 1'b1; bus.s_axi_bready = 1'b0;
        @(posedge aclk); #1;
        bus.s_axi_awvalid = 1'b0; bus.s_axi_wvalid = 1'b0;
        bus.s_axi_araddr = 32'h8; bus.s_axi_arvalid = 1'b1; bus.s_axi_rready = 1'b0;
        @(posedge aclk); #1;
        bus.s_axi_arvalid = 1'b0;
        @(negedge aclk);
        check("collide_rdata_old", bus.s_axi_rdata, old_v);
        check("collide_valids", {bus.s_axi_rvalid, bus.s_axi_bvalid}, 2'b11);
        @(posedge aclk); #1;
        bus.s_axi_rready = 1'b1; bus.s_axi_bready = 1'b1;
        @(posedge aclk); #1;
        bus.s_axi_rready = 1'b0; bus.s_axi_bready = 1'b0;
        void'(model_write(32'h8, new_v, 4'hF));
        axi_read(32'h8, rd, rs);
        check("collide_rdata_new", rd, new_v);

        // Randomized traffic against the model.
        for (int i = 0; i < 60; i++) begin
            a = ($urandom_range(0, 7) == 0) ? (32'h10 << $urandom_range(0, 27)) : 32'h0;
            a = a | (32'($urandom_range(0, 3)) << 2) | 32'($urandom_range(0, 3));
            d = $urandom;
            s = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 1) == 1) begin
                axi_write(a, d, s, rs);
                check($sformatf("rand%0d_bresp@%h", i, a), rs, model_write(a, d, s));
            end else begin
                axi_read(a, rd, rs);
                check($sformatf("rand%0d_rdata@%h", i, a), rd, model_read(a));
                check($sformatf("rand%0d_rresp@%h", i, a), rs, model_rresp(a));
            end
        end

        // Reset with a write half-accepted and a read response stalled.
        void'(model_write(32'h0, 32'h13579BDF, 4'hF));
        axi_write(32'h0, 32'h13579BDF, 4'hF, rs);
        @(posedge aclk); #1;
        bus.s_axi_awaddr = 32'h4; bus.s_axi_awvalid = 1'b1; bus.s_axi_bready = 1'b1;
        bus.s_axi_araddr = 32'h0; bus.s_axi_arvalid = 1'b1; bus.s_axi_rready = 1'b0;
        @(posedge aclk); #1;
        bus.s_axi_awvalid = 1'b0; bus.s_axi_arvalid = 1'b0;
        @(negedge aclk);
        check("midrst_pending", {bus.s_axi_rvalid, bus.s_axi_awready}, 2'b10);
        #2;
        aresetn = 1'b0;
        #1;
        check("midrst_outputs_drop",
              {bus.s_axi_bvalid, bus.s_axi_rvalid, bus.s_axi_awready,
               bus.s_axi_wready, bus.s_axi_arready}, 0);
        for (int i = 0; i < 3; i++) m_regs[i] = '0;
        bus.s_axi_rready = 1'b0; bus.s_axi_bready = 1'b1;
        repeat (2) @(posedge aclk);
        #2;
        aresetn = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge aclk);
            check("midrst_no_bvalid", {bus.s_axi_bvalid, bus.s_axi_rvalid}, 0);
        end
        bus.s_axi_bready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            axi_read(32'(i * 4), rd, rs);
            check($sformatf("midrst_reg%0d_zero", i), rd, model_read(32'(i * 4)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
